// File: rtl/spart_pkg.sv
// spart_pkg: shared definitions for the serial transmitter.
//   state_t           - transmit FSM states (IDLE, START, DATA, STOP)
//   DATA_BITS         - data bits per frame
//   STOP_BITS         - stop bits per frame
//   IDLE_LEVEL        - serial line level when idle and during the stop bit
//   DEFAULT_BAUD_DIV  - default clk cycles per serial bit period
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned STOP_BITS        = 1;
    localparam logic        IDLE_LEVEL       = 1'b1;
    localparam logic [15:0] DEFAULT_BAUD_DIV = 16'd326;

endpackage

// File: rtl/spart_tx_fifo.sv
// spart_tx_fifo: byte FIFO feeding the serial transmitter.
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset (empties the FIFO)
//   push  - enqueue din; ignored while the FIFO is full
//   pop   - dequeue the head byte; ignored while the FIFO is empty
//   din   - byte to enqueue
//   dout  - head byte (valid while empty=0)
//   full  - registered, high when occupancy == DEPTH
//   empty - high when occupancy == 0
module spart_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    // Acceptance depends only on pre-edge occupancy, so a push into a full
    // FIFO is dropped even when a pop frees a slot on the same edge.
    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && (count != '0);

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == FULL_CNT);
        end
    end

    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/spart_tx.sv
// spart_tx: FIFO-buffered asynchronous serial transmitter (8N1, LSB first).
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset; aborts any frame, empties FIFO
//   send      - enqueue strobe for send_data
//   send_data - byte to enqueue
//   full      - FIFO holds FIFO_DEPTH bytes; further sends are dropped
//   TxD       - serial output, registered, idle high
//   tx_idle   - FSM idle and FIFO empty
module spart_tx
    import spart_pkg::*;
#(
    parameter logic [15:0] BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] send_data,
    output logic       full,
    output logic       TxD,
    output logic       tx_idle
);

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        baud_end;
    logic        fifo_pop;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;

    spart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (send),
        .pop   (fifo_pop),
        .din   (send_data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty)
    );

    assign baud_end = (baud_cnt == BAUD_DIV - 16'd1);

    // Head byte is taken from IDLE, or at the end of STOP so frames run
    // back to back with no idle gap.
    assign fifo_pop = !fifo_empty &&
                      ((state == IDLE) || ((state == STOP) && baud_end));

    assign tx_idle = (state == IDLE) && fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            TxD       <= IDLE_LEVEL;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (fifo_pop) begin
                        shift_reg <= fifo_dout;
                        bit_idx   <= '0;
                        state     <= START;
                        TxD       <= 1'b0;
                    end
                end

                START: begin
                    baud_cnt <= baud_end ? '0 : baud_cnt + 16'd1;
                    if (baud_end) begin
                        state <= DATA;
                        TxD   <= shift_reg[0];
                    end
                end

                DATA: begin
                    baud_cnt <= baud_end ? '0 : baud_cnt + 16'd1;
                    if (baud_end) begin
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state <= STOP;
                            TxD   <= IDLE_LEVEL;
                        end else begin
                            // shift_reg[1] becomes shift_reg[0] on this edge
                            TxD <= shift_reg[1];
                        end
                    end
                end

                STOP: begin
                    baud_cnt <= baud_end ? '0 : baud_cnt + 16'd1;
                    if (baud_end) begin
                        if (fifo_pop) begin
                            shift_reg <= fifo_dout;
                            bit_idx   <= '0;
                            state     <= START;
                            TxD       <= 1'b0;
                        end else begin
                            state <= IDLE;
                            TxD   <= IDLE_LEVEL;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    TxD   <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spart_tx.sv
// tb_spart_tx: directed self-checking bench for spart_tx (BAUD_DIV=4, FIFO_DEPTH=8).
module tb_spart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       send;
    logic [7:0] send_data;
    logic       full;
    logic       TxD;
    logic       tx_idle;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spart_tx #(
        .BAUD_DIV   (16'd4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .send      (send),
        .send_data (send_data),
        .full      (full),
        .TxD       (TxD),
        .tx_idle   (tx_idle)
    );

    // Line waveform of one frame, one entry per clk cycle (4 cycles per bit).
    function automatic logic [39:0] frame_wave(input logic [7:0] b);
        logic [9:0]  bits;
        logic [39:0] w;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) w[i] = bits[i/4];
        return w;
    endfunction

    // Expected TxD k cycles after the first push edge, for n frames packed in q
    // (frame 0 in q[7:0]); the first frame starts one edge after that push.
    function automatic logic exp_line(input logic [71:0] q, input int n, input int k);
        logic [39:0] w;
        int          f;
        if (k < 1 || k > 40 * n) return 1'b1;
        f = (k - 1) / 40;
        w = frame_wave(q[f*8 +: 8]);
        return w[(k - 1) % 40];
    endfunction

    task automatic test_reset();
        rst = 1'b0; send = 1'b0; send_data = 8'h00;
        repeat (3) @(negedge clk);
        tests++; if (TxD !== 1'b1)     begin fails++; $display("FAIL reset_txd got %b exp 1", TxD); end
        tests++; if (full !== 1'b0)    begin fails++; $display("FAIL reset_full got %b exp 0", full); end
        tests++; if (tx_idle !== 1'b1) begin fails++; $display("FAIL reset_idle got %b exp 1", tx_idle); end
        send = 1'b1; send_data = 8'h5A;
        @(negedge clk);
        tests++; if (tx_idle !== 1'b1) begin fails++; $display("FAIL reset_push_ignored got %b exp 1", tx_idle); end
        send = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (TxD !== 1'b1)     begin fails++; $display("FAIL post_reset_txd got %b exp 1", TxD); end
        tests++; if (tx_idle !== 1'b1) begin fails++; $display("FAIL post_reset_idle got %b exp 1", tx_idle); end
    endtask

    task automatic test_single_frame();
        logic [71:0] q;
        logic        e;
        q = {64'h0, 8'hA5};
        @(negedge clk);
        send = 1'b1; send_data = 8'hA5;
        for (int k = 0; k <= 41; k++) begin
            @(negedge clk);
            e = exp_line(q, 1, k);
            tests++; if (TxD !== e) begin fails++; $display("FAIL single_txd k=%0d got %b exp %b", k, TxD, e); end
            if (k == 20) begin
                tests++; if (tx_idle !== 1'b0) begin fails++; $display("FAIL single_busy got %b exp 0", tx_idle); end
            end
            if (k == 41) begin
                tests++; if (tx_idle !== 1'b1) begin fails++; $display("FAIL single_done_idle got %b exp 1", tx_idle); end
            end
            if (k == 0) send = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] q;
        logic        e;
        q = {48'h0, 8'h03, 8'h02, 8'h01};
        @(negedge clk);
        send = 1'b1; send_data = 8'h01;
        for (int k = 0; k <= 121; k++) begin
            @(negedge clk);
            e = exp_line(q, 3, k);
            tests++; if (TxD !== e) begin fails++; $display("FAIL b2b_txd k=%0d got %b exp %b", k, TxD, e); end
            if (k == 121) begin
                tests++; if (tx_idle !== 1'b1) begin fails++; $display("FAIL b2b_done_idle got %b exp 1", tx_idle); end
            end
            if (k == 0) send_data = 8'h02;
            if (k == 1) send_data = 8'h03;
            if (k == 2) send = 1'b0;
        end
    endtask

    task automatic test_overflow();
        logic [71:0] q;
        logic        e;
        for (int i = 0; i < 9; i++) q[i*8 +: 8] = 8'h10 + 8'(i);
        @(negedge clk);
        send = 1'b1; send_data = 8'h10;
        for (int k = 0; k <= 361; k++) begin
            @(negedge clk);
            e = exp_line(q, 9, k);
            tests++; if (TxD !== e) begin fails++; $display("FAIL ovf_txd k=%0d got %b exp %b", k, TxD, e); end
            if (k == 7) begin
                tests++; if (full !== 1'b0) begin fails++; $display("FAIL ovf_not_full got %b exp 0", full); end
            end
            if (k == 8 || k == 9 || k == 40) begin
                tests++; if (full !== 1'b1) begin fails++; $display("FAIL ovf_full k=%0d got %b exp 1", k, full); end
            end
            if (k == 41) begin
                tests++; if (full !== 1'b0) begin fails++; $display("FAIL ovf_after_pop got %b exp 0", full); end
            end
            if (k == 361) begin
                tests++; if (tx_idle !== 1'b1) begin fails++; $display("FAIL ovf_done_idle got %b exp 1", tx_idle); end
            end
            if (k <= 8) send_data = 8'h11 + 8'(k);
            if (k == 9) send = 1'b0;
        end
    endtask

    task automatic test_push_at_pop();
        logic [71:0] q;
        logic        e;
        for (int i = 0; i < 9; i++) q[i*8 +: 8] = 8'h20 + 8'(i);
        @(negedge clk);
        send = 1'b1; send_data = 8'h20;
        for (int k = 0; k <= 361; k++) begin
            @(negedge clk);
            e = exp_line(q, 9, k);
            tests++; if (TxD !== e) begin fails++; $display("FAIL pop_push_txd k=%0d got %b exp %b", k, TxD, e); end
            if (k == 8 || k == 40) begin
                tests++; if (full !== 1'b1) begin fails++; $display("FAIL pop_push_full k=%0d got %b exp 1", k, full); end
            end
            if (k == 41) begin
                tests++; if (full !== 1'b0) begin fails++; $display("FAIL pop_push_full_clear got %b exp 0", full); end
                tests++; if (dut.u_fifo.count !== 4'd7) begin fails++; $display("FAIL pop_push_count got %0d exp 7", dut.u_fifo.count); end
            end
            if (k == 361) begin
                tests++; if (tx_idle !== 1'b1) begin fails++; $display("FAIL pop_push_done_idle got %b exp 1", tx_idle); end
            end
            if (k <= 7) send_data = 8'h21 + 8'(k);
            if (k == 8) send = 1'b0;
            if (k == 40) begin send = 1'b1; send_data = 8'hEE; end
            if (k == 41) send = 1'b0;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [71:0] q;
        logic        e;
        q = {40'h0, 8'h33, 8'h32, 8'h31, 8'hFF};
        @(negedge clk);
        send = 1'b1; send_data = 8'hFF;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            e = exp_line(q, 4, k);
            tests++; if (TxD !== e) begin fails++; $display("FAIL rstmid_txd k=%0d got %b exp %b", k, TxD, e); end
            if (k == 0) send_data = 8'h31;
            if (k == 1) send_data = 8'h32;
            if (k == 2) send_data = 8'h33;
            if (k == 3) send = 1'b0;
        end
        @(negedge clk);
        tests++; if (full !== 1'b0 || tx_idle !== 1'b0) begin fails++; $display("FAIL rstmid_busy full=%b idle=%b exp 0/0", full, tx_idle); end
        rst = 1'b0;
        #1;
        tests++; if (TxD !== 1'b1)     begin fails++; $display("FAIL rstmid_txd_async got %b exp 1", TxD); end
        tests++; if (tx_idle !== 1'b1) begin fails++; $display("FAIL rstmid_idle_async got %b exp 1", tx_idle); end
        tests++; if (full !== 1'b0)    begin fails++; $display("FAIL rstmid_full_async got %b exp 0", full); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            tests++; if (TxD !== 1'b1) begin fails++; $display("FAIL rstmid_quiet_txd k=%0d got %b exp 1", k, TxD); end
        end
        tests++; if (tx_idle !== 1'b1) begin fails++; $display("FAIL rstmid_final_idle got %b exp 1", tx_idle); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_push_at_pop();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
